ov7670_config_sequencer: RTL and testbench
==========================================

Name: ov7670_config_sequencer

Overview:
Reader side of the OV7670 configuration ROM. After a start pulse it walks ROM addresses from 0 upward and decodes each 16-bit word as {reg, data}. It hands each register write to the SCCB initiator over a valid/ready + done handshake, and inserts a timed wait for the delay marker. It stops at the end marker and raises done; the camera datapath waits on done before capturing.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency.
DELAY_MS, 10, wait time for a 16'hFFF0 delay entry.
ADDR_W, 8, ROM address width.
DELAY_CYCLES, CLK_FREQ_HZ/1000*DELAY_MS (localparam), 500_000 at defaults; counter width is $clog2(DELAY_CYCLES+1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse to begin configuration.
rom_addr  out  ADDR_W  address to the config ROM.
rom_dout  in  16  ROM data; registered, valid the cycle after rom_addr is stable.
cmd_valid  out  1  SCCB write request.
cmd_ready  in  1  SCCB initiator accepts a request.
cmd_reg  out  8  register address, equal to rom_dout[15:8].
cmd_data  out  8  register value, equal to rom_dout[7:0].
xfer_done  in  1  one-cycle pulse when the SCCB write completes.
xfer_nack  in  1  sampled with xfer_done; 1 means the slave did not acknowledge.
busy  out  1  sequence in progress.
done  out  1  sequence complete (level).
err  out  1  sticky: at least one NACK in this run.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; rom_addr=0; cmd_valid=0; cmd_reg=0; cmd_data=0; busy=0; done=0; err=0; delay counter=0. Reset asserted mid-sequence aborts immediately; cmd_valid drops and no partial handshake state remains.
- IDLE: on start, rom_addr<=0, done<=0, err<=0, busy<=1, go to FETCH.
- start is ignored while busy. start while done=1 restarts the full sequence.
- FETCH: one cycle with rom_addr stable; the ROM registers the word. Go to DECODE.
- DECODE: rom_dout is valid this cycle.
  - 16'hFFFF: go to FINISH.
  - 16'hFFF0: load delay counter with DELAY_CYCLES-1, go to DELAY.
  - Any other word: latch cmd_reg/cmd_data, assert cmd_valid, go to SEND.
- SEND: hold cmd_valid, cmd_reg and cmd_data stable until cmd_ready=1 in the same cycle as cmd_valid=1. Then cmd_valid<=0, go to WAIT_DONE.
- WAIT_DONE: wait for xfer_done. If xfer_nack=1 on that cycle, set err (the sequence still continues). Go to NEXT.
  - xfer_done seen in SEND before acceptance is ignored.
- DELAY: decrement each cycle; at 0 go to NEXT. Total DELAY_CYCLES cycles spent in DELAY.
- NEXT: if rom_addr is all ones (255), go to FINISH with no wrap. Otherwise rom_addr<=rom_addr+1, go to FETCH.
- FINISH: busy<=0, done<=1, go to IDLE. done stays high until the next start or reset.
- Latency:
  - start to first cmd_valid = 3 cycles (IDLE->FETCH->DECODE->SEND, cmd_valid registered on entry to SEND).
  - xfer_done to next cmd_valid = 4 cycles (NEXT, FETCH, DECODE, SEND).
- cmd_valid is never asserted outside SEND. At most one request is outstanding at a time.

Decomposition:
- Package ov7670_cfg_pkg:
  - ROM_END = 16'hFFFF and ROM_DELAY = 16'hFFF0, shared with the ROM.
  - Enum cfg_state_t {IDLE, FETCH, DECODE, SEND, WAIT_DONE, DELAY, NEXT, FINISH}.
- Sub-module cfg_delay_timer (load, count value, expired flag), reusable for the SCCB bit-timing counters.

Test Plan:
1. ROM model {0:1280, 1:FFF0, 2:1204, 3:FFFF}, cmd_ready tied 1, xfer_done 5 cycles after acceptance, DELAY_MS overridden so DELAY_CYCLES=20.
   - Required: writes (12,80) then (12,04), exactly 20 cycles in DELAY between them.
   - Required: done=1, busy=0, err=0 at the end; no write issued for FFFF.
2. Backpressure: cmd_ready held low 7 cycles on the first request.
   - Required: cmd_valid/cmd_reg/cmd_data remain stable for all 8 cycles; exactly one write is accepted.
3. xfer_nack=1 on the second xfer_done of a 3-write ROM.
   - Required: err rises on that cycle and stays 1; the third write is still issued; done=1 at the end.
4. ROM with no FFFF entry, all addresses 0..255 = 1100.
   - Required: 256 writes, then done=1; rom_addr never wraps to 0 while busy.
5. rst_n pulled low while in SEND and during DELAY.
   - Required: all outputs return to their reset values immediately; a new start replays from address 0.
6. start pulses while busy, and start after done.
   - Required: the pulses while busy are ignored.
   - Required: start after done clears done and err and issues the first cmd_valid exactly 3 cycles later.

Source files
------------

// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 configuration ROM and its reader.
package ov7670_cfg_pkg;

  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_DONE,
    DELAY,
    NEXT,
    FINISH
  } cfg_state_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter that parks at zero; expired_o is high while the count is zero.
module cfg_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM from address 0, issuing SCCB writes and timed waits
// until the end marker (or the last address), then holds done.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DELAY_MS    = 10,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_dout_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [7:0]        cmd_reg_o,
  output logic [7:0]        cmd_data_o,
  input  logic              xfer_done_i,
  input  logic              xfer_nack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int CNT_W        = $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);

  cfg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              dly_load;
  logic              dly_expired;
  logic [CNT_W-1:0]  unused_dly_cnt;

  cfg_delay_timer #(.W(CNT_W)) u_dly (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (dly_load),
    .en_i       (state_q == DELAY),
    .load_val_i (DLY_LOAD),
    .cnt_o      (unused_dly_cnt),
    .expired_o  (dly_expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    reg_d    = reg_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    dly_load = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        addr_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_dout_i == ROM_END) begin
          state_d = FINISH;
        end else if (rom_dout_i == ROM_DELAY) begin
          dly_load = 1'b1;
          state_d  = DELAY;
        end else begin
          reg_d   = rom_dout_i[15:8];
          data_d  = rom_dout_i[7:0];
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      // xfer_done is deliberately not looked at until the request is accepted
      SEND: if (cmd_ready_i) begin
        valid_d = 1'b0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (xfer_done_i) begin
        if (xfer_nack_i) err_d = 1'b1;
        state_d = NEXT;
      end
      DELAY: if (dly_expired) state_d = NEXT;
      // A ROM without an end marker stops at the last address instead of wrapping
      NEXT: if (&addr_q) begin
        state_d = FINISH;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign cmd_valid_o = valid_q;
  assign cmd_reg_o   = reg_q;
  assign cmd_data_o  = data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench: registered ROM, SCCB slave model with stalls/latency/NACKs, list-level reference model.
module tb_ov7670_config_sequencer;

  localparam int NDLY = 20;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_reg, cmd_data;
  logic        xfer_done, xfer_nack;
  logic        busy, done, err;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(.CLK_FREQ_HZ(20000), .DELAY_MS(1), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .rom_addr_o(rom_addr), .rom_dout_i(rom_dout),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_reg_o(cmd_reg), .cmd_data_o(cmd_data),
    .xfer_done_i(xfer_done), .xfer_nack_i(xfer_nack),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  logic [15:0] mem [0:255];
  always @(posedge clk) rom_dout <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] outs;
  assign outs = {rom_addr, cmd_valid, cmd_reg, cmd_data, busy, done, err};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // slave model state
  logic [15:0] wr_q[$];
  int          vcyc_q[$], dcyc_q[$], hold_q[$];
  bit          nack_plan [0:511];
  bit          in_req, outstanding, rand_stall, spur_en;
  bit          prev_err, prev_busy;
  logic [7:0]  prev_addr;
  logic [15:0] req_w;
  int          hold, stall_left, dlat, dlat_left, viol, errcyc;

  initial begin
    cmd_ready = 1'b0; xfer_done = 1'b0; xfer_nack = 1'b0;
    in_req = 0; outstanding = 0; prev_err = 0; prev_busy = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      xfer_done = 1'b0; xfer_nack = 1'b0;
      if (!rst_n) begin
        in_req = 0; outstanding = 0; stall_left = 0; cmd_ready = 1'b0;
      end else begin
        if (busy && prev_busy && prev_addr == 8'hFF && rom_addr == 8'h00) viol++;
        if (busy && prev_busy && prev_err && !err) viol++;
        if (err && !prev_err) errcyc = cyc;
        if (outstanding) begin
          if (dlat_left == 0) begin
            xfer_done = 1'b1;
            xfer_nack = nack_plan[wr_q.size()-1];
            outstanding = 0;
            dcyc_q.push_back(cyc);
          end else dlat_left--;
        end
        if (cmd_valid) begin
          if (!in_req) begin
            in_req = 1; req_w = {cmd_reg, cmd_data}; vcyc_q.push_back(cyc); hold = 0;
            if (rand_stall) stall_left = $urandom_range(0, 3);
            if (outstanding) viol++;
          end else if ({cmd_reg, cmd_data} !== req_w) viol++;
          hold++;
          if (stall_left > 0) begin
            cmd_ready = 1'b0; stall_left--;
            if (spur_en && !outstanding && $urandom_range(0, 1) == 1) begin
              xfer_done = 1'b1; xfer_nack = 1'b1;
            end
          end else begin
            cmd_ready = 1'b1;
            wr_q.push_back(req_w); hold_q.push_back(hold);
            in_req = 0; outstanding = 1; dlat_left = dlat - 1;
          end
        end else begin
          if (in_req) begin viol++; in_req = 0; end
          cmd_ready = (stall_left == 0);
        end
      end
      prev_addr = rom_addr; prev_err = err; prev_busy = busy;
    end
  end

  task automatic rom_fill(input logic [15:0] w);
    for (int a = 0; a < 256; a++) mem[a] = w;
  endtask

  task automatic clear_nacks();
    for (int i = 0; i < 512; i++) nack_plan[i] = 0;
  endtask

  // Reference: expected write list and timing derived from the ROM image alone.
  task automatic run_seq(input string tag, input bit spam);
    logic [15:0] exp_q[$];
    int k_q[$];
    int k, s, n, base, tdone;
    bit exp_err, end_ff;
    k = 0; end_ff = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] == 16'hFFFF) begin end_ff = 1; break; end
      else if (mem[a] == 16'hFFF0) k++;
      else begin exp_q.push_back(mem[a]); k_q.push_back(k); k = 0; end
    end
    exp_err = 0;
    for (int i = 0; i < exp_q.size(); i++) exp_err |= nack_plan[i];
    wr_q.delete(); vcyc_q.delete(); dcyc_q.delete(); hold_q.delete();
    viol = 0; errcyc = -1;
    @(negedge clk); start = 1'b1; s = cyc;
    @(negedge clk); start = 1'b0;
    chk({tag, ".clr"}, {busy, done, err}, 3'b100);
    n = 0;
    while (!done && n < 40000) begin
      @(negedge clk); n++;
      start = (spam && busy && $urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    tdone = cyc;
    chk({tag, ".timeout"}, n < 40000, 1);
    chk({tag, ".end"}, {busy, done, err}, {2'b01, exp_err});
    chk({tag, ".nwr"}, wr_q.size(), exp_q.size());
    chk({tag, ".viol"}, viol, 0);
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("%s.wr%0d", tag, i), wr_q[i], exp_q[i]);
      if (i < vcyc_q.size() && (i == 0 || i - 1 < dcyc_q.size()))
        chk($sformatf("%s.gap%0d", tag, i),
            vcyc_q[i] - ((i == 0) ? s : dcyc_q[i-1]),
            ((i == 0) ? 3 : 4) + k_q[i] * (NDLY + 3));
    end
    base = (exp_q.size() == 0) ? s - 1 :
           (dcyc_q.size() > 0 ? dcyc_q[dcyc_q.size()-1] : -1000);
    chk({tag, ".tdone"}, tdone - base, (end_ff ? 5 : 3) + k * (NDLY + 3));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    rand_stall = 0; spur_en = 0; stall_left = 0; dlat = 5;
    clear_nacks(); rom_fill(16'hFFFF);
    repeat (3) @(negedge clk);
    chk("reset.outs", outs, 0);
    #2 rst_n = 1'b1;

    // directed: write, delay, write, end
    mem[0] = 16'h1280; mem[1] = 16'hFFF0; mem[2] = 16'h1204; mem[3] = 16'hFFFF;
    run_seq("t1", 0);

    // backpressure on the first request
    rom_fill(16'hFFFF); mem[0] = 16'h1A55; mem[1] = 16'h3C0F;
    stall_left = 7;
    run_seq("t2", 0);
    chk("t2.hold", (hold_q.size() > 0) ? hold_q[0] : 0, 8);

    // NACK on the second of three writes
    rom_fill(16'hFFFF); mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0506;
    nack_plan[1] = 1;
    run_seq("t3", 0);
    chk("t3.errcyc", errcyc, (dcyc_q.size() > 1) ? dcyc_q[1] + 1 : -1);
    clear_nacks();

    // no end marker: every address is a write
    rom_fill(16'h1100);
    run_seq("t4", 0);

    // reset while a request is stalled in SEND
    rom_fill(16'hFFFF); mem[0] = 16'h2A11; mem[1] = 16'h2B22;
    stall_left = 30;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!cmd_valid && n < 20) begin @(negedge clk); n++; end
    chk("t5.insend", {cmd_valid, cmd_reg, cmd_data}, 17'h12A11);
    #2 rst_n = 1'b0;
    #1 chk("t5.rst_send", outs, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    // reset in the middle of a delay entry
    mem[0] = 16'hFFF0;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5.indelay", {busy, cmd_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("t5.rst_delay", outs, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    mem[0] = 16'h2A11; mem[1] = 16'hFFF0; mem[2] = 16'h2B22;
    run_seq("t5", 0);

    // start pulses while busy, then restart after done clears err
    rom_fill(16'hFFFF);
    mem[0] = 16'h4411; mem[1] = 16'h4522; mem[2] = 16'hFFF0; mem[3] = 16'h4633;
    nack_plan[0] = 1;
    run_seq("t6a", 1);
    clear_nacks();
    run_seq("t6b", 0);

    // randomized ROM images, stalls, latencies, NACKs
    for (int it = 0; it < 8; it++) begin
      int len;
      logic [15:0] w;
      rom_fill(16'hFFFF);
      len = $urandom_range(1, 6);
      for (int a = 0; a < len; a++) begin
        if ($urandom_range(0, 4) == 0) mem[a] = 16'hFFF0;
        else begin
          w = 16'($urandom);
          if (w >= 16'hFFF0) w = w & 16'h7FFF;
          mem[a] = w;
        end
      end
      for (int i = 0; i < 8; i++) nack_plan[i] = ($urandom_range(0, 3) == 0);
      dlat = $urandom_range(1, 6);
      rand_stall = 1; spur_en = 1;
      run_seq($sformatf("rnd%0d", it), it[0]);
      rand_stall = 0; spur_en = 0; stall_left = 0; clear_nacks();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
